// File: rtl/expr_pkg.sv
// Shared definitions for the expression stream blocks: FSM state encoding and
// the ASCII codes of the characters the grammar understands.
package expr_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    NUM   = 2'd1,
    OP    = 2'd2,
    ERR   = 2'd3
  } state_t;

  localparam logic [7:0] CHAR_0    = 8'h30;
  localparam logic [7:0] CHAR_9    = 8'h39;
  localparam logic [7:0] CHAR_PLUS = 8'h2B;
  localparam logic [7:0] CHAR_STAR = 8'h2A;

endpackage

// File: rtl/expr_char_class.sv
// Combinational decode of one ASCII byte into digit/plus/star classes and the
// numeric value of a digit.
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0] in,
  output logic       is_digit,
  output logic       is_plus,
  output logic       is_star,
  output logic [3:0] digit_val
);

  assign is_digit = (in >= CHAR_0) && (in <= CHAR_9);
  assign is_plus  = (in == CHAR_PLUS);
  assign is_star  = (in == CHAR_STAR);

  // ASCII digits sit at 0x30..0x39, so the low nibble is already the value.
  assign digit_val = is_digit ? in[3:0] : 4'd0;

endmodule

// File: rtl/expr_eval.sv
// Streaming evaluator for single-digit "+"/"*" infix expressions with normal
// precedence; reports running value, completeness, syntax error and overflow.
module expr_eval
  import expr_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         in_valid,
  input  logic [7:0]   in,
  output logic [W-1:0] result,
  output logic         result_valid,
  output logic         err,
  output logic         ovf
);

  state_t         r_state;
  logic [W-1:0]   r_sum;
  logic [W-1:0]   r_prod;
  logic [W-1:0]   r_term;
  logic [W-1:0]   r_result;
  logic           r_resultValid;
  logic           r_err;
  logic           r_ovf;

  logic           w_isDigit;
  logic           w_isPlus;
  logic           w_isStar;
  logic [3:0]     w_digitVal;
  logic [W+3:0]   w_prodDig;
  logic [W:0]     w_sumDig;
  logic [W:0]     w_sumTerm;
  logic           w_prodOvf;

  expr_char_class u_class (
    .in        (in),
    .is_digit  (w_isDigit),
    .is_plus   (w_isPlus),
    .is_star   (w_isStar),
    .digit_val (w_digitVal)
  );

  // Widened arithmetic: any set bit above W marks an overflow.
  assign w_prodDig = {4'b0000, r_prod} * {{W{1'b0}}, w_digitVal};
  assign w_prodOvf = |w_prodDig[W+3:W];
  assign w_sumDig  = {1'b0, r_sum} + {1'b0, w_prodDig[W-1:0]};
  assign w_sumTerm = {1'b0, r_sum} + {1'b0, r_term};

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state       <= EMPTY;
      r_sum         <= '0;
      r_prod        <= W'(1);
      r_term        <= '0;
      r_result      <= '0;
      r_resultValid <= 1'b0;
      r_err         <= 1'b0;
      r_ovf         <= 1'b0;
    end else if (in_valid) begin
      case (r_state)
        EMPTY, OP: begin
          if (w_isDigit) begin
            r_term        <= w_prodDig[W-1:0];
            r_result      <= w_sumDig[W-1:0];
            r_resultValid <= 1'b1;
            r_ovf         <= r_ovf | w_prodOvf | w_sumDig[W];
            r_state       <= NUM;
          end else begin
            r_state       <= ERR;
            r_err         <= 1'b1;
            r_resultValid <= 1'b0;
          end
        end
        NUM: begin
          if (w_isPlus) begin
            r_sum         <= w_sumTerm[W-1:0];
            r_prod        <= W'(1);
            r_resultValid <= 1'b0;
            r_ovf         <= r_ovf | w_sumTerm[W];
            r_state       <= OP;
          end else if (w_isStar) begin
            r_prod        <= r_term;
            r_resultValid <= 1'b0;
            r_state       <= OP;
          end else begin
            r_state       <= ERR;
            r_err         <= 1'b1;
            r_resultValid <= 1'b0;
          end
        end
        default: begin
          // ERR is absorbing until reset; everything holds.
        end
      endcase
    end
  end

  assign result       = r_result;
  assign result_valid = r_resultValid;
  assign err          = r_err;
  assign ovf          = r_ovf;

endmodule

// File: tb/tb_expr_eval.sv
// Directed scoreboard bench for expr_eval at W=8: every driven step pushes its
// hand-computed expected outputs, which are popped and checked one edge later.
module tb_expr_eval;

  typedef struct {
    string      tag;
    logic [7:0] res;
    logic       vld;
    logic       er;
    logic       ov;
  } exp_t;

  logic       clk;
  logic       clr_n;
  logic       inValid;
  logic [7:0] inChar;
  logic [7:0] result;
  logic       resultValid;
  logic       err;
  logic       ovf;

  exp_t sbQueue[$];
  int   checks = 0;
  int   errors = 0;

  expr_eval #(.W(8)) dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .in_valid     (inValid),
    .in           (inChar),
    .result       (result),
    .result_valid (resultValid),
    .err          (err),
    .ovf          (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expectOut(input string tag, input logic [7:0] res,
                           input logic vld, input logic er, input logic ov);
    exp_t e;
    e.tag = tag;
    e.res = res;
    e.vld = vld;
    e.er  = er;
    e.ov  = ov;
    sbQueue.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sbQueue.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sbQueue.pop_front();
      checks++;
      assert (result === e.res) else begin
        errors++;
        $error("FAIL %s.result observed=%0d expected=%0d", e.tag, result, e.res);
      end
      checks++;
      assert (resultValid === e.vld) else begin
        errors++;
        $error("FAIL %s.result_valid observed=%b expected=%b", e.tag, resultValid, e.vld);
      end
      checks++;
      assert (err === e.er) else begin
        errors++;
        $error("FAIL %s.err observed=%b expected=%b", e.tag, err, e.er);
      end
      checks++;
      assert (ovf === e.ov) else begin
        errors++;
        $error("FAIL %s.ovf observed=%b expected=%b", e.tag, ovf, e.ov);
      end
    end
  endtask

  // Drive one character for exactly one accepted edge, then check 1 ns later.
  task automatic applyStimulus(input logic [7:0] ch, input string tag, input logic [7:0] res,
                               input logic vld, input logic er, input logic ov);
    @(negedge clk);
    inValid = 1'b1;
    inChar  = ch;
    expectOut(tag, res, vld, er, ov);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    checkOutput();
  endtask

  // An idle cycle with a junk byte on the bus that must be ignored.
  task automatic idleCycle(input string tag, input logic [7:0] res,
                           input logic vld, input logic er, input logic ov);
    @(negedge clk);
    inValid = 1'b0;
    inChar  = "x";
    expectOut(tag, res, vld, er, ov);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Assert reset between edges and check it takes effect without a clock.
  task automatic resetDut(input string tag);
    #2;
    clr_n = 1'b0;
    #1;
    expectOut(tag, 8'd0, 1'b0, 1'b0, 1'b0);
    checkOutput();
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  initial begin
    clr_n   = 1'b1;
    inValid = 1'b0;
    inChar  = 8'h00;
    $display("[TB] expr_eval W=8 directed run");

    resetDut("reset");

    // Precedence: 1+2*3 = 7
    applyStimulus("1", "prec_1",  8'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus("+", "prec_p",  8'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus("2", "prec_2",  8'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus("*", "prec_s",  8'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus("3", "prec_3",  8'd7, 1'b1, 1'b0, 1'b0);

    // Mixed products: 2*3+4*5 = 26
    resetDut("rst_mix");
    applyStimulus("2", "mix_2",  8'd2,  1'b1, 1'b0, 1'b0);
    applyStimulus("*", "mix_s1", 8'd2,  1'b0, 1'b0, 1'b0);
    applyStimulus("3", "mix_3",  8'd6,  1'b1, 1'b0, 1'b0);
    applyStimulus("+", "mix_p",  8'd6,  1'b0, 1'b0, 1'b0);
    applyStimulus("4", "mix_4",  8'd10, 1'b1, 1'b0, 1'b0);
    applyStimulus("*", "mix_s2", 8'd10, 1'b0, 1'b0, 1'b0);
    applyStimulus("5", "mix_5",  8'd26, 1'b1, 1'b0, 1'b0);

    // Syntax error: 1++2, then absorbing
    resetDut("rst_syn");
    applyStimulus("1", "syn_1",  8'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus("+", "syn_p1", 8'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus("+", "syn_p2", 8'd1, 1'b0, 1'b1, 1'b0);
    applyStimulus("2", "syn_2",  8'd1, 1'b0, 1'b1, 1'b0);
    applyStimulus("*", "syn_s",  8'd1, 1'b0, 1'b1, 1'b0);

    // Operator at the very start
    resetDut("rst_opstart");
    applyStimulus("*", "opstart", 8'd0, 1'b0, 1'b1, 1'b0);

    // Two digits in a row
    resetDut("rst_dd");
    applyStimulus("1", "dd_1", 8'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus("2", "dd_2", 8'd1, 1'b0, 1'b1, 1'b0);

    // Bytes just outside the digit range
    resetDut("rst_slash");
    applyStimulus("/", "slash", 8'd0, 1'b0, 1'b1, 1'b0);
    resetDut("rst_colon");
    applyStimulus("5", "colon_5", 8'd5, 1'b1, 1'b0, 1'b0);
    applyStimulus("+", "colon_p", 8'd5, 1'b0, 1'b0, 1'b0);
    applyStimulus(":", "colon",   8'd5, 1'b0, 1'b1, 1'b0);

    // Product overflow: 9*9*9 = 729 -> 217
    resetDut("rst_ovf");
    applyStimulus("9", "ovf_9a", 8'd9,   1'b1, 1'b0, 1'b0);
    applyStimulus("*", "ovf_s1", 8'd9,   1'b0, 1'b0, 1'b0);
    applyStimulus("9", "ovf_9b", 8'd81,  1'b1, 1'b0, 1'b0);
    applyStimulus("*", "ovf_s2", 8'd81,  1'b0, 1'b0, 1'b0);
    applyStimulus("9", "ovf_9c", 8'd217, 1'b1, 1'b0, 1'b1);

    // Sum carry overflow: 9*9*3+9*9 = 324 -> 68, then sticky through "+"
    resetDut("rst_carry");
    applyStimulus("9", "car_9a", 8'd9,   1'b1, 1'b0, 1'b0);
    applyStimulus("*", "car_s1", 8'd9,   1'b0, 1'b0, 1'b0);
    applyStimulus("9", "car_9b", 8'd81,  1'b1, 1'b0, 1'b0);
    applyStimulus("*", "car_s2", 8'd81,  1'b0, 1'b0, 1'b0);
    applyStimulus("3", "car_3",  8'd243, 1'b1, 1'b0, 1'b0);
    applyStimulus("+", "car_p1", 8'd243, 1'b0, 1'b0, 1'b0);
    applyStimulus("9", "car_9c", 8'd252, 1'b1, 1'b0, 1'b0);
    applyStimulus("*", "car_s3", 8'd252, 1'b0, 1'b0, 1'b0);
    applyStimulus("9", "car_9d", 8'd68,  1'b1, 1'b0, 1'b1);
    applyStimulus("+", "car_p2", 8'd68,  1'b0, 1'b0, 1'b1);

    // Valid gaps: 3*4 with two idle cycles between characters
    resetDut("rst_gap");
    applyStimulus("3", "gap_3",  8'd3,  1'b1, 1'b0, 1'b0);
    idleCycle("gap_i1", 8'd3, 1'b1, 1'b0, 1'b0);
    idleCycle("gap_i2", 8'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus("*", "gap_s",  8'd3,  1'b0, 1'b0, 1'b0);
    idleCycle("gap_i3", 8'd3, 1'b0, 1'b0, 1'b0);
    idleCycle("gap_i4", 8'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus("4", "gap_4",  8'd12, 1'b1, 1'b0, 1'b0);

    // Async reset mid-stream, then a fresh expression
    resetDut("rst_async0");
    applyStimulus("5", "ar_5", 8'd5,  1'b1, 1'b0, 1'b0);
    applyStimulus("+", "ar_p", 8'd5,  1'b0, 1'b0, 1'b0);
    applyStimulus("6", "ar_6", 8'd11, 1'b1, 1'b0, 1'b0);
    resetDut("ar_reset");
    applyStimulus("7", "ar_7", 8'd7,  1'b1, 1'b0, 1'b0);
    applyStimulus("*", "ar_s", 8'd7,  1'b0, 1'b0, 1'b0);
    applyStimulus("2", "ar_2", 8'd14, 1'b1, 1'b0, 1'b0);

    if (sbQueue.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sbQueue.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
